// File: rtl/phy_tx_framer.sv
// phy_tx_framer
//   Transmit-side framer for the PCIe PHY logical sub-block. Takes byte-wide
//   TLP/DLLP beats on a valid/ready handshake and emits one registered symbol
//   per clock: STP/SDP, data bytes, END/EDB, IDL fill and periodic SKP
//   ordered sets (COM + SKP_COUNT x SKP). Malformed framing is reported on
//   ERROR_FRAME and the offending packet is nullified with EDB.
//
// Parameters
//   SKP_INTERVAL  cycles between SKP ordered sets (>= 8)
//   SKP_COUNT     SKP symbols after each COM (1..7)
//   MAX_LEN       maximum data bytes per packet (>= 1)
//
// Ports
//   CLK          clock, rising edge
//   RESET        synchronous, active-high reset
//   IN_VALID     beat valid
//   IN_READY     beat accepted when IN_VALID & IN_READY (combinational)
//   IN_DATA      payload byte
//   IN_SOP       first beat of packet
//   IN_EOP       last beat of packet
//   IN_TYPE      with SOP: 0 = TLP (STP), 1 = DLLP (SDP)
//   IN_ABORT     with EOP: 1 = end with EDB instead of END
//   DATA_OUT     registered symbol
//   CONTROL_OUT  registered class: 00 data, 01 start/end, 10 COM, 11 SKP/IDL
//   ERROR_FRAME  registered one-cycle pulse on a framing error
module phy_tx_framer #(
   parameter int SKP_INTERVAL = 64,
   parameter int SKP_COUNT    = 3,
   parameter int MAX_LEN      = 32
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [7:0] IN_DATA,
   input  logic       IN_SOP,
   input  logic       IN_EOP,
   input  logic       IN_TYPE,
   input  logic       IN_ABORT,
   output logic [7:0] DATA_OUT,
   output logic [1:0] CONTROL_OUT,
   output logic       ERROR_FRAME
);
   localparam int TW = $clog2(SKP_INTERVAL + 1);
   localparam int LW = $clog2(MAX_LEN + 1);

   localparam logic [7:0] SYM_STP = 8'hfb;
   localparam logic [7:0] SYM_SDP = 8'h5c;
   localparam logic [7:0] SYM_END = 8'hfd;
   localparam logic [7:0] SYM_EDB = 8'hfe;
   localparam logic [7:0] SYM_COM = 8'hbc;
   localparam logic [7:0] SYM_SKP = 8'h1c;
   localparam logic [7:0] SYM_IDL = 8'h7c;

   localparam logic [1:0] C_DATA = 2'b00;
   localparam logic [1:0] C_FRM  = 2'b01;
   localparam logic [1:0] C_COM  = 2'b10;
   localparam logic [1:0] C_OS   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE, ST_DATA, ST_END, ST_DROP, ST_SKP_COM, ST_SKP_BODY
   } state_t;

   state_t          state;
   logic [TW-1:0]   skp_timer;
   logic [LW-1:0]   len;
   logic [2:0]      skp_body;
   logic            abort_q;
   logic            skp_due;

   assign skp_due = (skp_timer >= TW'(SKP_INTERVAL));

   // SOP is never consumed in IDLE: the same beat is taken again as the
   // first data byte once the start symbol has gone out. A stray non-SOP
   // beat in IDLE is swallowed so the source cannot wedge.
   always_comb begin
      IN_READY = 1'b0;
      case (state)
         ST_IDLE:          IN_READY = IN_VALID & ~IN_SOP & ~skp_due;
         ST_DATA, ST_DROP: IN_READY = 1'b1;
         default:          IN_READY = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         skp_timer   <= '0;
         len         <= '0;
         skp_body    <= '0;
         abort_q     <= 1'b0;
         DATA_OUT    <= SYM_IDL;
         CONTROL_OUT <= C_OS;
         ERROR_FRAME <= 1'b0;
      end else begin
         ERROR_FRAME <= 1'b0;
         DATA_OUT    <= SYM_IDL;
         CONTROL_OUT <= C_OS;
         if (!skp_due)
            skp_timer <= skp_timer + TW'(1);

         case (state)
            ST_IDLE: begin
               if (skp_due) begin
                  state     <= ST_SKP_COM;
                  skp_timer <= '0;
               end else if (IN_VALID && IN_SOP) begin
                  DATA_OUT    <= IN_TYPE ? SYM_SDP : SYM_STP;
                  CONTROL_OUT <= C_FRM;
                  len         <= '0;
                  state       <= ST_DATA;
               end else if (IN_VALID) begin
                  ERROR_FRAME <= 1'b1;
               end
            end
            ST_DATA: begin
               if (!IN_VALID) begin
                  // underrun: nullify what is already on the wire
                  DATA_OUT    <= SYM_EDB;
                  CONTROL_OUT <= C_FRM;
                  ERROR_FRAME <= 1'b1;
                  state       <= ST_DROP;
               end else if (len < LW'(MAX_LEN)) begin
                  DATA_OUT    <= IN_DATA;
                  CONTROL_OUT <= C_DATA;
                  len         <= len + LW'(1);
                  if (IN_SOP && len != '0)
                     ERROR_FRAME <= 1'b1;
                  if (IN_EOP) begin
                     abort_q <= IN_ABORT;
                     state   <= ST_END;
                  end
               end else begin
                  // over-length: nullify, then drop the rest unless this was the last beat
                  DATA_OUT    <= SYM_EDB;
                  CONTROL_OUT <= C_FRM;
                  ERROR_FRAME <= 1'b1;
                  state       <= IN_EOP ? ST_IDLE : ST_DROP;
               end
            end
            ST_END: begin
               DATA_OUT    <= abort_q ? SYM_EDB : SYM_END;
               CONTROL_OUT <= C_FRM;
               if (skp_due) begin
                  state     <= ST_SKP_COM;
                  skp_timer <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (IN_VALID && IN_EOP)
                  state <= ST_IDLE;
            end
            ST_SKP_COM: begin
               // timer stays parked while the ordered set is on the wire, so the
               // interval measures traffic/idle time between sets
               DATA_OUT    <= SYM_COM;
               CONTROL_OUT <= C_COM;
               skp_timer   <= '0;
               skp_body    <= '0;
               state       <= ST_SKP_BODY;
            end
            ST_SKP_BODY: begin
               DATA_OUT    <= SYM_SKP;
               CONTROL_OUT <= C_OS;
               skp_timer   <= '0;
               skp_body    <= skp_body + 3'd1;
               if (skp_body == 3'(SKP_COUNT - 1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
